enum_seq_checker: RTL and testbench



---
 rtl/enum_seq_checker.sv | 185 ++++++++++++++++++
 tb/tb_enum_seq_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/enum_seq_checker.sv
// -----------------------------------------------------------------------------
// enum_seq_checker
//
// Receive-side monitor for the enum state-sequencer stream. On every cycle
// with in_valid high it samples a 2-bit state code and checks that the codes
// follow S0 -> S1 -> S2 -> S0. The checker first hunts for an S0, then needs
// LOCK_N consecutive correct transitions before it declares lock. Once locked,
// any deviation raises a one-cycle error pulse, bumps a saturating error
// counter and sends the checker back to hunting.
//
// Parameters
//   W_CNT   width of the saturating error counter
//   LOCK_N  consecutive correct transitions needed to lock (>= 1)
//
// Ports
//   clk         in   1      clock, all logic on posedge
//   rst         in   1      synchronous reset, active-high (overrides in_valid)
//   in_valid    in   1      in_state is sampled on this edge
//   in_state    in   2      00=S0, 01=S1, 10=S2, 11=illegal
//   locked      out  1      high while the checker is in LOCKED
//   exp_state   out  2      next expected code
//   err_pulse   out  1      one-cycle pulse on a deviation while locked
//   err_cnt     out  W_CNT  number of locked deviations, saturating
//   cycle_done  out  1      one-cycle pulse when S2->S0 completes while locked
//
// All outputs are registered: the response to a sample appears the cycle
// after the edge that sampled it.
// -----------------------------------------------------------------------------
module enum_seq_checker #(
    parameter int W_CNT  = 8,
    parameter int LOCK_N = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [1:0]       in_state,
    output logic             locked,
    output logic [1:0]       exp_state,
    output logic             err_pulse,
    output logic [W_CNT-1:0] err_cnt,
    output logic             cycle_done
);

    // good_cnt has to hold the value LOCK_N itself on the locking transition.
    localparam int GC_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;

    typedef enum logic [1:0] {
        HUNT   = 2'b00,
        SYNC   = 2'b01,
        LOCKED = 2'b10
    } chk_state_t;

    // Successor of a legal code; the illegal code maps to S0 so that the
    // expected value can never itself become illegal.
    function automatic logic [1:0] next_code(input logic [1:0] code);
        logic [1:0] nxt;
        case (code)
            S0:      nxt = S1;
            S1:      nxt = S2;
            default: nxt = S0;
        endcase
        return nxt;
    endfunction

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [W_CNT-1:0] sat_inc(input logic [W_CNT-1:0] val);
        logic [W_CNT-1:0] res;
        if (&val) begin
            res = val;
        end else begin
            res = val + W_CNT'(1);
        end
        return res;
    endfunction

    chk_state_t       state;
    chk_state_t       state_n;
    logic [1:0]       exp_n;
    logic [GC_W-1:0]  good_cnt;
    logic [GC_W-1:0]  good_n;
    logic [GC_W-1:0]  good_inc;
    logic [W_CNT-1:0] err_cnt_n;
    logic             err_pulse_n;
    logic             cycle_done_n;
    logic             match;

    // The illegal code 11 never equals exp_state, so it always mismatches.
    assign match    = (in_state == exp_state);
    assign good_inc = good_cnt + GC_W'(1);

    // -------------------------------------------------------------------------
    // Next-state and next-output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        exp_n        = exp_state;
        good_n       = good_cnt;
        err_cnt_n    = err_cnt;
        err_pulse_n  = 1'b0;
        cycle_done_n = 1'b0;

        if (in_valid) begin
            case (state)
                HUNT: begin
                    // Only an S0 can start a sequence; anything else is
                    // silently skipped.
                    if (in_state == S0) begin
                        state_n = SYNC;
                        exp_n   = S1;
                        good_n  = '0;
                    end
                end

                SYNC: begin
                    if (match) begin
                        good_n = good_inc;
                        exp_n  = next_code(exp_state);
                        if (good_inc == GC_W'(LOCK_N)) begin
                            state_n = LOCKED;
                        end
                    end else if (in_state == S0) begin
                        // An out-of-order S0 is a fresh start, not a loss.
                        exp_n  = S1;
                        good_n = '0;
                    end else begin
                        state_n = HUNT;
                        exp_n   = S0;
                        good_n  = '0;
                    end
                end

                LOCKED: begin
                    if (match) begin
                        exp_n = next_code(exp_state);
                        if (in_state == S0) begin
                            cycle_done_n = 1'b1;
                        end
                    end else begin
                        // Every deviation, including a stray S0, drops lock
                        // and goes back to hunting.
                        err_pulse_n = 1'b1;
                        err_cnt_n   = sat_inc(err_cnt);
                        state_n     = HUNT;
                        exp_n       = S0;
                        good_n      = '0;
                    end
                end

                default: begin
                    state_n = HUNT;
                    exp_n   = S0;
                    good_n  = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            locked     <= 1'b0;
            exp_state  <= S0;
            good_cnt   <= '0;
            err_cnt    <= '0;
            err_pulse  <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            state      <= state_n;
            locked     <= (state_n == LOCKED);
            exp_state  <= exp_n;
            good_cnt   <= good_n;
            err_cnt    <= err_cnt_n;
            err_pulse  <= err_pulse_n;
            cycle_done <= cycle_done_n;
        end
    end

endmodule

// File: tb/tb_enum_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_enum_seq_checker
//
// Directed bench for enum_seq_checker. Two instances share the same stimulus:
// dut uses the default 8-bit error counter, dut2 a 2-bit one so saturation is
// reachable. Every step drives one input vector, waits one edge, and compares
// the packed outputs of both instances against a hand-computed expectation.
// -----------------------------------------------------------------------------
module tb_enum_seq_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_state;

    logic       locked,     locked2;
    logic [1:0] exp_state,  exp_state2;
    logic       err_pulse,  err_pulse2;
    logic [7:0] err_cnt;
    logic [1:0] err_cnt2;
    logic       cycle_done, cycle_done2;

    logic [19:0] obs;

    int n_vec = 0;
    int n_err = 0;

    enum_seq_checker #(.W_CNT(8), .LOCK_N(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_state   (in_state),
        .locked     (locked),
        .exp_state  (exp_state),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .cycle_done (cycle_done)
    );

    enum_seq_checker #(.W_CNT(2), .LOCK_N(3)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_state   (in_state),
        .locked     (locked2),
        .exp_state  (exp_state2),
        .err_pulse  (err_pulse2),
        .err_cnt    (err_cnt2),
        .cycle_done (cycle_done2)
    );

    always #5 clk = ~clk;

    assign obs = {locked, exp_state, err_pulse, cycle_done, err_cnt,
                  locked2, exp_state2, err_pulse2, cycle_done2, err_cnt2};

    // Expected packed outputs of both instances.
    function automatic logic [19:0] pack(input logic l, input logic [1:0] e,
                                         input logic p, input logic c,
                                         input logic [7:0] n, input logic [1:0] n2);
        return {l, e, p, c, n, l, e, p, c, n2};
    endfunction

    // Apply one vector, then move 1 time unit past the edge to observe.
    task automatic drive(input logic v, input logic [1:0] s);
        in_valid = v;
        in_state = s;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [19:0] e;
        rst = 1'b1;
        drive(1'b1, 2'd0);
        drive(1'b1, 2'd0);
        rst = 1'b0;
        e = pack(0, 2'd0, 0, 0, 8'd0, 2'd0);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_values: got %h want %h", obs, e);
        end
        drive(1'b0, 2'd3);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL reset_idle_hold: got %h want %h", obs, e);
        end
    endtask

    // 0,1,2,0,1,2,0 from reset: lock after the 4th, cycle_done after the 7th.
    task automatic test_lock;
        logic [1:0] s_t [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        logic       l_t [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] x_t [7] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        logic       c_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [19:0] e;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, s_t[i]);
            e = pack(l_t[i], x_t[i], 0, c_t[i], 8'd0, 2'd0);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL lock step %0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    // Continues from the locked state left by test_lock (exp_state = S1).
    task automatic test_error;
        logic        v_t [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0]  s_t [8] = '{2'd1, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0};
        logic [19:0] e_t [8];
        e_t[0] = pack(1, 2'd2, 0, 0, 8'd0, 2'd0);
        e_t[1] = pack(1, 2'd0, 0, 0, 8'd0, 2'd0);
        e_t[2] = pack(0, 2'd0, 1, 0, 8'd1, 2'd1);   // 1 where 0 expected
        e_t[3] = pack(0, 2'd0, 0, 0, 8'd1, 2'd1);   // idle: pulse gone
        e_t[4] = pack(0, 2'd1, 0, 0, 8'd1, 2'd1);
        e_t[5] = pack(0, 2'd2, 0, 0, 8'd1, 2'd1);
        e_t[6] = pack(0, 2'd0, 0, 0, 8'd1, 2'd1);
        e_t[7] = pack(1, 2'd1, 0, 0, 8'd1, 2'd1);   // relocked, no cycle_done
        for (int i = 0; i < 8; i++) begin
            drive(v_t[i], s_t[i]);
            n_vec++;
            if (obs !== e_t[i]) begin
                n_err++;
                $display("FAIL error step %0d: got %h want %h", i, obs, e_t[i]);
            end
        end
    endtask

    // HUNT skipping, SYNC loss on 11, SYNC restart on a stray S0.
    task automatic test_sync;
        logic [1:0]  s_t [12] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd3,
                                  2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd0};
        logic [1:0]  x_t [12] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0,
                                  2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1};
        logic [19:0] e;
        rst = 1'b1;
        drive(1'b0, 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, s_t[i]);
            e = pack((i == 11), x_t[i], 0, 0, 8'd0, 2'd0);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL sync step %0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    // Five deviations with relock in between; the 2-bit counter sticks at 3.
    task automatic test_saturate;
        logic [1:0]  dev_t [5] = '{2'd3, 2'd2, 2'd0, 2'd3, 2'd2};
        logic [1:0]  n2;
        logic [19:0] e;
        rst = 1'b1;
        drive(1'b0, 2'd0);
        rst = 1'b0;
        drive(1'b1, 2'd0);
        drive(1'b1, 2'd1);
        drive(1'b1, 2'd2);
        drive(1'b1, 2'd0);
        for (int k = 1; k <= 5; k++) begin
            n2 = (k > 3) ? 2'd3 : 2'(k);
            drive(1'b1, dev_t[k-1]);
            e = pack(0, 2'd0, 1, 0, 8'(k), n2);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL sat_dev %0d: got %h want %h", k, obs, e);
            end
            drive(1'b1, 2'd0);
            drive(1'b1, 2'd1);
            drive(1'b1, 2'd2);
            drive(1'b1, 2'd0);
            e = pack(1, 2'd1, 0, 0, 8'(k), n2);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL sat_relock %0d: got %h want %h", k, obs, e);
            end
        end
    endtask

    // Same stream as test_lock with an idle cycle after every sample.
    task automatic test_idle;
        logic [1:0] s_t [7] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0};
        logic       l_t [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [1:0] x_t [7] = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
        logic       c_t [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [19:0] e;
        rst = 1'b1;
        drive(1'b0, 2'd0);
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, s_t[i]);
            e = pack(l_t[i], x_t[i], 0, c_t[i], 8'd0, 2'd0);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL idle_valid step %0d: got %h want %h", i, obs, e);
            end
            drive(1'b0, 2'd3);
            e = pack(l_t[i], x_t[i], 0, 0, 8'd0, 2'd0);
            n_vec++;
            if (obs !== e) begin
                n_err++;
                $display("FAIL idle_hold step %0d: got %h want %h", i, obs, e);
            end
        end
    endtask

    // Reset while locked with a matching sample on the same edge.
    task automatic test_rst_mid;
        logic [19:0] e;
        drive(1'b1, 2'd3);
        drive(1'b1, 2'd0);
        drive(1'b1, 2'd1);
        drive(1'b1, 2'd2);
        drive(1'b1, 2'd0);
        e = pack(1, 2'd1, 0, 0, 8'd1, 2'd1);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL pre_rst_lock: got %h want %h", obs, e);
        end
        rst = 1'b1;
        drive(1'b1, 2'd1);
        rst = 1'b0;
        e = pack(0, 2'd0, 0, 0, 8'd0, 2'd0);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL rst_mid: got %h want %h", obs, e);
        end
        drive(1'b1, 2'd2);
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL post_rst_hunt: got %h want %h", obs, e);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_state = 2'd0;
        test_reset();
        test_lock();
        test_error();
        test_sync();
        test_saturate();
        test_idle();
        test_rst_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
